// File: rtl/reg_file_param_if.sv
// Register file bus: read/write ports plus clear-engine handshake.
interface reg_file_param_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned ADDR_W = $clog2(DEPTH);

   logic              Wen;
   logic [ADDR_W-1:0] w_addr;
   logic [WIDTH-1:0]  dataIn;
   logic [ADDR_W-1:0] r_addr1;
   logic [ADDR_W-1:0] r_addr2;
   logic [WIDTH-1:0]  dataOut1;
   logic [WIDTH-1:0]  dataOut2;
   logic              clr_req;
   logic              busy;
   logic              clr_done;
   logic              wr_drop;

   modport master (
      output Wen, w_addr, dataIn, r_addr1, r_addr2, clr_req,
      input  dataOut1, dataOut2, busy, clr_done, wr_drop
   );

   modport slave (
      input  Wen, w_addr, dataIn, r_addr1, r_addr2, clr_req,
      output dataOut1, dataOut2, busy, clr_done, wr_drop
   );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised 2-read/1-write register file with a sequenced clear engine,
// out-of-range address protection and write-drop indication.
// Optional macro REGFILE_BYPASS_EN: forward an accepted same-cycle write
// to any read port addressing the same entry.
module reg_file_param #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input logic             clk,
   input logic             rst_n,
   reg_file_param_if.slave bus
);
   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned AW1    = ADDR_W + 1;
   localparam logic [AW1-1:0]    DEPTH_W = AW1'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic              busy_q, busy_d;
   logic              clr_done_q, clr_done_d;
   logic              wr_drop_q, wr_drop_d;
   logic              wr_en;
   logic              clr_en;
   logic              w_in_range;

   assign w_in_range = ({1'b0, bus.w_addr} < DEPTH_W);

   // State, sweep index and registered status outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         busy_q     <= 1'b0;
         clr_done_q <= 1'b0;
         wr_drop_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         busy_q     <= busy_d;
         clr_done_q <= clr_done_d;
         wr_drop_q  <= wr_drop_d;
      end
   end

   // Next state, sweep control and write qualification
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      wr_en      = 1'b0;
      clr_en     = 1'b0;
      clr_done_d = 1'b0;
      wr_drop_d  = 1'b0;
      case (state_q)
         IDLE: begin
            wr_en     = bus.Wen && w_in_range;
            wr_drop_d = bus.Wen && !w_in_range;
            if (bus.clr_req) begin
               state_d = CLEAR;
               idx_d   = '0;
            end
         end
         CLEAR: begin
            clr_en    = 1'b1;
            wr_drop_d = bus.Wen;
            if (idx_q == LAST) begin
               state_d    = IDLE;
               clr_done_d = 1'b1;
            end else begin
               idx_d = idx_q + ADDR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == CLEAR);
   end

   // Storage: reset wipe, sweep clear, or accepted write
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (clr_en) begin
         mem_q[idx_q] <= '0;
      end else if (wr_en) begin
         mem_q[bus.w_addr] <= bus.dataIn;
      end
   end

   // Combinational read ports; out-of-range addresses read zero
   always_comb begin
      bus.dataOut1 = '0;
      bus.dataOut2 = '0;
      if ({1'b0, bus.r_addr1} < DEPTH_W) bus.dataOut1 = mem_q[bus.r_addr1];
      if ({1'b0, bus.r_addr2} < DEPTH_W) bus.dataOut2 = mem_q[bus.r_addr2];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (bus.r_addr1 == bus.w_addr)) bus.dataOut1 = bus.dataIn;
      if (wr_en && (bus.r_addr2 == bus.w_addr)) bus.dataOut2 = bus.dataIn;
`endif
   end

   assign bus.busy     = busy_q;
   assign bus.clr_done = clr_done_q;
   assign bus.wr_drop  = wr_drop_q;
endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param (DEPTH=5 to exercise out-of-range
// addresses and a non-power-of-two sweep).
module tb_reg_file_param;
   localparam int unsigned WIDTH  = 8;
   localparam int unsigned DEPTH  = 5;
   localparam int unsigned ADDR_W = $clog2(DEPTH);

   logic clk = 1'b0;
   logic rst_n;

   reg_file_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   reg_file_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: contents, sweep progress and expected status flags
   int   m_mem [DEPTH];
   bit   m_valid    = 0;
   bit   m_sweeping = 0;
   int   m_pos      = 0;
   bit   m_busy = 0, m_done = 0, m_drop = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int exp_read(input int addr);
      int v;
      v = (addr < DEPTH) ? m_mem[addr] : 0;
`ifdef REGFILE_BYPASS_EN
      if (!m_sweeping && bus.Wen && int'(bus.w_addr) < DEPTH && int'(bus.w_addr) == addr)
         v = int'(bus.dataIn);
`endif
      return v;
   endfunction

   // Model advances on each rising edge from the inputs presented there
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
         m_sweeping = 0; m_pos = 0;
         m_busy = 0; m_done = 0; m_drop = 0;
         m_valid = 1;
      end else if (m_valid) begin
         m_done = 0; m_drop = 0;
         if (m_sweeping) begin
            m_drop = bus.Wen;
            m_mem[m_pos] = 0;
            m_pos++;
            if (m_pos == DEPTH) begin
               m_sweeping = 0;
               m_done = 1;
            end
         end else begin
            if (bus.Wen) begin
               if (int'(bus.w_addr) < DEPTH) m_mem[bus.w_addr] = int'(bus.dataIn);
               else m_drop = 1;
            end
            if (bus.clr_req) begin
               m_sweeping = 1;
               m_pos = 0;
            end
         end
         m_busy = m_sweeping;
      end
   end

   // Every-cycle comparison, mid-cycle on the falling edge
   always @(negedge clk) begin
      if (m_valid) begin
         chk("dataOut1", 32'(bus.dataOut1), 32'(exp_read(int'(bus.r_addr1))));
         chk("dataOut2", 32'(bus.dataOut2), 32'(exp_read(int'(bus.r_addr2))));
         chk("busy",     32'(bus.busy),     32'(m_busy));
         chk("clr_done", 32'(bus.clr_done), 32'(m_done));
         chk("wr_drop",  32'(bus.wr_drop),  32'(m_drop));
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.Wen = 0; bus.w_addr = '0; bus.dataIn = '0;
      bus.clr_req = 0; bus.r_addr1 = '0; bus.r_addr2 = '0;
   endtask

   initial begin
      int cnt;
      rst_n = 0;
      idle_inputs();
      cycle(); cycle();
      rst_n = 1;

      // Reset then read
      bus.r_addr1 = 3'd0; bus.r_addr2 = 3'(DEPTH - 1);
      #1;
      chk("lit_rst_rd1", 32'(bus.dataOut1), 32'h00);
      chk("lit_rst_rd2", 32'(bus.dataOut2), 32'h00);
      chk("lit_rst_busy", 32'(bus.busy), 32'h0);

      // Write then read; same-cycle read depends on forwarding
      bus.Wen = 1; bus.w_addr = 3'd2; bus.dataIn = 8'hA5; bus.r_addr1 = 3'd2;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("lit_same_cycle", 32'(bus.dataOut1), 32'hA5);
`else
      chk("lit_same_cycle", 32'(bus.dataOut1), 32'h00);
`endif
      cycle();
      bus.Wen = 0; bus.r_addr1 = 3'd2; bus.r_addr2 = 3'd2;
      #1;
      chk("lit_wr_rd1", 32'(bus.dataOut1), 32'hA5);
      chk("lit_wr_rd2", 32'(bus.dataOut2), 32'hA5);

      // Load all entries, then sweep
      for (int i = 0; i < DEPTH; i++) begin
         bus.Wen = 1; bus.w_addr = 3'(i); bus.dataIn = 8'(8'h11 * (i + 1));
         cycle();
      end
      bus.Wen = 0; bus.clr_req = 1;
      cycle();                                  // clr_req sampled
      bus.clr_req = 0;
      #1;
      chk("lit_busy_rise", 32'(bus.busy), 32'h1);
      bus.Wen = 1; bus.w_addr = 3'd3; bus.dataIn = 8'hFF;
      cycle();                                  // 1st sweep edge, write dropped
      bus.Wen = 0;
      #1;
      chk("lit_drop_clear", 32'(bus.wr_drop), 32'h1);
      cycle();                                  // 2nd sweep edge
      bus.r_addr1 = 3'd1; bus.r_addr2 = 3'd2;
      #1;
      chk("lit_sweep_rd1", 32'(bus.dataOut1), 32'h00);
      chk("lit_sweep_rd2", 32'(bus.dataOut2), 32'h33);
      bus.r_addr1 = 3'd3;
      #1;
      chk("lit_sweep_rd3", 32'(bus.dataOut1), 32'h44);
      cycle(); cycle();                         // 3rd, 4th sweep edges
      chk("lit_busy_mid", 32'(bus.busy), 32'h1);
      chk("lit_done_early", 32'(bus.clr_done), 32'h0);
      cycle();                                  // 5th (last) sweep edge
      chk("lit_busy_fall", 32'(bus.busy), 32'h0);
      chk("lit_done_pulse", 32'(bus.clr_done), 32'h1);
      cycle();
      chk("lit_done_once", 32'(bus.clr_done), 32'h0);
      bus.r_addr1 = 3'd3; bus.r_addr2 = 3'd4;
      #1;
      chk("lit_after_rd3", 32'(bus.dataOut1), 32'h00);
      chk("lit_after_rd4", 32'(bus.dataOut2), 32'h00);

      // Out-of-range write and read
      bus.Wen = 1; bus.w_addr = 3'd6; bus.dataIn = 8'h77;
      cycle();
      bus.Wen = 0; bus.r_addr1 = 3'd7;
      #1;
      chk("lit_oor_drop", 32'(bus.wr_drop), 32'h1);
      chk("lit_oor_rd", 32'(bus.dataOut1), 32'h00);

      // Reset in the middle of a sweep
      bus.Wen = 1; bus.w_addr = 3'd1; bus.dataIn = 8'h5A;
      cycle();
      bus.Wen = 0; bus.clr_req = 1;
      cycle();
      bus.clr_req = 0;
      cycle();                                  // 1st sweep edge
      rst_n = 0;
      cycle();                                  // reset lands on 2nd sweep edge
      rst_n = 1;
      chk("lit_rst_busy_mid", 32'(bus.busy), 32'h0);
      chk("lit_rst_no_done", 32'(bus.clr_done), 32'h0);
      bus.r_addr1 = 3'd1;
      #1;
      chk("lit_rst_entry1", 32'(bus.dataOut1), 32'h00);
      cycle();
      chk("lit_rst_no_done2", 32'(bus.clr_done), 32'h0);
      bus.clr_req = 1;
      cycle();
      bus.clr_req = 0;
      cnt = 0;
      while (bus.busy && cnt < 50) begin
         cnt++;
         cycle();
      end
      chk("lit_full_sweep_len", 32'(cnt), 32'(DEPTH));
      chk("lit_full_sweep_done", 32'(bus.clr_done), 32'h1);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst_n       = ($urandom_range(0, 99) != 0);
         bus.Wen     = $urandom_range(0, 1);
         bus.w_addr  = 3'($urandom_range(0, 7));
         bus.dataIn  = 8'($urandom);
         bus.r_addr1 = 3'($urandom_range(0, 7));
         bus.r_addr2 = ($urandom_range(0, 3) == 0) ? bus.w_addr : 3'($urandom_range(0, 7));
         bus.clr_req = ($urandom_range(0, 19) == 0);
         cycle();
      end
      rst_n = 1;
      idle_inputs();
      cycle(); cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
